// File: rtl/uart_rx_buffered_pkg.sv
// uart_rx_buffered_pkg
//   Shared definitions for the UART receive path: receiver FSM state
//   encoding and the bit-time calculation used to size the baud counters.
`timescale 1ns/1ps
package uart_rx_buffered_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_t;

  // Clock cycles per serial bit (integer division, truncates).
  function automatic int bit_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_buffered_sync_fifo.sv
// uart_rx_buffered_sync_fifo
//   First-word-fall-through synchronous FIFO, generic enough for the TX path.
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   wr_en, wr_data  push request; accepted when not full or when popping
//   rd_en           pop request; ignored when empty
//   rd_data         head entry, forced to 0 while empty
//   full, empty     occupancy flags
//   count           occupied entries
`timescale 1ns/1ps
module uart_rx_buffered_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || rd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered
//   Serial receive front end: RX pin -> 2-flop synchronizer -> 8N1 deframer
//   -> byte FIFO, drained by the CPU over a ready/valid handshake.
// Ports
//   clk             system clock
//   rst             asynchronous active-high reset
//   serial_in       raw RX line, idles high, asynchronous to clk
//   data_out        byte at FIFO head (0 while empty)
//   data_out_valid  FIFO not empty
//   data_out_ready  consumer pop; pop happens on valid & ready
//   fifo_count      occupied FIFO entries
//   overrun         1-cycle pulse: complete byte dropped, FIFO full
//   framing_error   1-cycle pulse: stop bit sampled low, byte discarded
//
// state   | meaning
// S_IDLE  | waiting for a falling edge (or for the line to go high after a framing error)
// S_START | timing to the centre of the start bit to reject glitches
// S_DATA  | sampling 8 data bits at bit centres, LSB first
// S_STOP  | sampling the stop bit, then push or flag framing error
`timescale 1ns/1ps
module uart_rx_buffered
  import uart_rx_buffered_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  output logic [7:0]                    data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          framing_error
);

  localparam int BIT_TIME = bit_time(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_BIT = BIT_TIME / 2;
  localparam int CW       = $clog2(BIT_TIME);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TIME - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  rx_state_t     state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          line_wait;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      state         <= S_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      line_wait     <= 1'b0;
      push          <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_meta       <= serial_in;
      rx_s          <= rx_meta;
      push          <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          // After a framing error the line may sit low (break); wait for idle.
          if (line_wait) begin
            if (rx_s) line_wait <= 1'b0;
          end else if (!rx_s) begin
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          // Leaving at the stop-bit centre gives half a bit of slack for the next start edge.
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (rx_s) begin
              push <= 1'b1;
            end else begin
              framing_error <= 1'b1;
              line_wait     <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pop            = data_out_valid && data_out_ready;
  assign data_out_valid = !fifo_empty;

  // shreg is stable until the next frame's first data sample, so it feeds the FIFO directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun <= 1'b0;
    else     overrun <= push && fifo_full && !pop;
  end

  uart_rx_buffered_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (shreg),
    .rd_en   (data_out_ready),
    .rd_data (data_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_buffered.sv
`timescale 1ns/1ps
module tb_uart_rx_buffered;

  // Faster line rate than the board default keeps the run short; all timing below scales from BIT.
  localparam int CLOCK_FREQ = 50_000_000;
  localparam int BAUD_RATE  = 2_500_000;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT  = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF = BIT / 2;
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            serial_in = 1'b1;
  logic            data_out_ready = 1'b0;
  logic [7:0]      data_out;
  logic            data_out_valid;
  logic [CNTW-1:0] fifo_count;
  logic            overrun;
  logic            framing_error;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  uart_rx_buffered #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .fifo_count     (fifo_count),
    .overrun        (overrun),
    .framing_error  (framing_error)
  );

  // Observer: records popped bytes, pulse cycles and head-stability violations.
  logic [7:0] got_q[$];
  int         ovr_n = 0;
  int         fe_n = 0;
  int         hold_bad = 0;
  logic       hold_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && data_out_valid && data_out !== data_prev) hold_bad++;
      hold_prev = data_out_valid && !data_out_ready;
      data_prev = data_out;
      if (data_out_valid && data_out_ready) got_q.push_back(data_out);
      if (overrun === 1'b1) ovr_n++;
      if (framing_error === 1'b1) fe_n++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model state
  logic [7:0] exp_q[$];
  logic [7:0] mq[$];
  int         exp_ovr;
  int         rd_i = 0;
  bit         tx_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller must be aligned 1 ns after a rising edge; returns aligned the same way.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    serial_in = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      wait_cyc(BIT);
    end
    serial_in = stop_bit;
    wait_cyc(BIT);
  endtask

  task automatic check_pops(input string tag);
    check({tag, "_npops"}, got_q.size() - rd_i, exp_q.size());
    foreach (exp_q[k])
      if (rd_i + k < got_q.size()) check(tag, got_q[rd_i + k], exp_q[k]);
    rd_i = got_q.size();
    exp_q.delete();
  endtask

  // Model of a non-draining FIFO receiving a burst: keep up to FIFO_DEPTH, count drops.
  task automatic model_fill(input logic [7:0] b);
    if (mq.size() < FIFO_DEPTH) mq.push_back(b);
    else exp_ovr++;
  endtask

  task automatic drain_and_check(input string tag);
    data_out_ready = 1'b1;
    wait_cyc(FIFO_DEPTH + 3);
    data_out_ready = 1'b0;
    exp_q = mq;
    mq.delete();
    check_pops(tag);
    check({tag, "_count0"}, fifo_count, 0);
  endtask

  initial begin
    int lat;
    int vc;
    int ovr0;
    int fe0;
    int n;
    logic [7:0] rb[$];

    // Reset state
    wait_cyc(3);
    check("rst_valid", data_out_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_framing", framing_error, 0);
    check("rst_data", data_out, 0);
    rst = 1'b0;
    wait_cyc(5);

    // T1: single byte, latency and a single valid cycle
    data_out_ready = 1'b1;
    ovr0 = ovr_n; fe0 = fe_n;
    lat = -1; vc = 0;
    fork
      send_frame(8'h61, 1'b1);
      begin
        for (int k = 1; k <= 12 * BIT; k++) begin
          @(posedge clk); #1;
          if (data_out_valid) begin
            vc++;
            if (lat < 0) lat = k;
          end
        end
      end
    join
    check("t1_latency_window", (lat >= HALF + 9 * BIT) && (lat <= HALF + 9 * BIT + 6), 1);
    check("t1_valid_cycles", vc, 1);
    exp_q.push_back(8'h61);
    check_pops("t1_data");
    check("t1_no_overrun", ovr_n - ovr0, 0);
    check("t1_no_framing", fe_n - fe0, 0);

    // T2: ten back-to-back frames
    ovr0 = ovr_n; fe0 = fe_n;
    for (int b = 8'h61; b <= 8'h6A; b++) begin
      send_frame(8'(b), 1'b1);
      exp_q.push_back(8'(b));
    end
    wait_cyc(10);
    check_pops("t2_burst");
    check("t2_no_overrun", ovr_n - ovr0, 0);
    check("t2_no_framing", fe_n - fe0, 0);

    // T2b: random bytes with random ready, every byte must arrive in order
    n = $urandom_range(3, 5);
    rb.delete();
    for (int i = 0; i < n; i++) rb.push_back(8'($urandom));
    exp_q = rb;
    tx_done = 1'b0;
    ovr0 = ovr_n;
    fork
      begin
        foreach (rb[i]) send_frame(rb[i], 1'b1);
        tx_done = 1'b1;
      end
      begin
        while (!tx_done) begin
          data_out_ready = 1'($urandom_range(0, 1));
          wait_cyc(1);
        end
        data_out_ready = 1'b1;
      end
    join
    wait_cyc(10);
    check_pops("t2b_random");
    check("t2b_no_overrun", ovr_n - ovr0, 0);

    // T3: no pops, five bytes into a 4-deep FIFO
    data_out_ready = 1'b0;
    ovr0 = ovr_n; exp_ovr = 0;
    mq.delete();
    for (int b = 8'h10; b <= 8'h14; b++) begin
      send_frame(8'(b), 1'b1);
      model_fill(8'(b));
    end
    wait_cyc(5);
    check("t3_count", fifo_count, mq.size());
    check("t3_overrun", ovr_n - ovr0, exp_ovr);
    check("t3_head", data_out, mq[0]);
    drain_and_check("t3_drain");

    // T4: full FIFO, single-cycle pop exactly when the fifth byte is written
    ovr0 = ovr_n;
    mq.delete();
    for (int b = 8'h10; b <= 8'h13; b++) begin
      send_frame(8'(b), 1'b1);
      mq.push_back(8'(b));
    end
    wait_cyc(2);
    check("t4_full_count", fifo_count, FIFO_DEPTH);
    fork
      send_frame(8'h14, 1'b1);
      begin
        wait_cyc(HALF + 9 * BIT + 3);
        data_out_ready = 1'b1;
        wait_cyc(1);
        data_out_ready = 1'b0;
      end
    join
    wait_cyc(3);
    exp_q.push_back(mq.pop_front());
    mq.push_back(8'h14);
    check_pops("t4_pulse_pop");
    check("t4_no_overrun", ovr_n - ovr0, 0);
    check("t4_count", fifo_count, FIFO_DEPTH);
    check("t4_head", data_out, mq[0]);
    drain_and_check("t4_drain");

    // T5: short low glitch is rejected, next frame is fine
    fe0 = fe_n;
    serial_in = 1'b0;
    wait_cyc(HALF / 2);
    serial_in = 1'b1;
    wait_cyc(2 * BIT);
    check("t5_glitch_count", fifo_count, 0);
    check("t5_glitch_framing", fe_n - fe0, 0);
    data_out_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    wait_cyc(10);
    exp_q.push_back(8'hA5);
    check_pops("t5_after_glitch");

    // T6: bad stop bit, line held low, then recovery
    data_out_ready = 1'b0;
    fe0 = fe_n; ovr0 = ovr_n;
    send_frame(8'h55, 1'b0);
    serial_in = 1'b0;
    wait_cyc(3 * BIT);
    check("t6_framing", fe_n - fe0, 1);
    check("t6_count", fifo_count, 0);
    serial_in = 1'b1;
    wait_cyc(BIT);
    data_out_ready = 1'b1;
    send_frame(8'h3C, 1'b1);
    wait_cyc(10);
    exp_q.push_back(8'h3C);
    check_pops("t6_recover");
    check("t6_framing_once", fe_n - fe0, 1);
    check("t6_no_overrun", ovr_n - ovr0, 0);

    // T7: reset mid-frame discards the FIFO and the partial byte
    data_out_ready = 1'b0;
    send_frame(8'h77, 1'b1);
    wait_cyc(5);
    check("t7_preload", fifo_count, 1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_cyc(5 * BIT);
        rst = 1'b1;
        #1;
        check("t7_rst_valid", data_out_valid, 0);
        check("t7_rst_count", fifo_count, 0);
        check("t7_rst_data", data_out, 0);
        wait_cyc(3);
        rst = 1'b0;
      end
    join
    wait_cyc(2 * BIT);
    check("t7_no_byte", fifo_count, 0);
    data_out_ready = 1'b1;
    send_frame(8'h0F, 1'b1);
    wait_cyc(10);
    exp_q.push_back(8'h0F);
    check_pops("t7_after_rst");

    // T8: random overflow burst
    data_out_ready = 1'b0;
    ovr0 = ovr_n; exp_ovr = 0;
    mq.delete();
    n = $urandom_range(2, 6);
    for (int i = 0; i < n; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      send_frame(r, 1'b1);
      model_fill(r);
    end
    wait_cyc(5);
    check("t8_count", fifo_count, mq.size());
    check("t8_overrun", ovr_n - ovr0, exp_ovr);
    check("t8_head", data_out, mq[0]);
    drain_and_check("t8_drain");

    check("head_stable_while_stalled", hold_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
